// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial controller sequencing an external 1-bit ALU slice
//
// Purpose: captures two WIDTH-bit operands, an opcode and an initial carry on an
// accepted start, then walks the operands LSB first through an external
// combinational 1-bit slice, chaining the carry through a register and
// assembling the result. done pulses for one cycle when result/cout are valid.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request; accepted only while ready is high
//   a, b, op, cin0      operands, opcode and initial carry, captured on accept
//   ready               high in IDLE and DONE
//   alu_a/b/cin/op      drive to the 1-bit slice (a/b/cin forced low outside RUN)
//   alu_s, alu_cout     slice outputs, combinational from alu_*
//   result, cout        last completed result and final carry
//   done                one-cycle completion pulse
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin0,
  output logic             ready,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_s,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_next;
  logic [1:0]       op_q;
  logic             carry_q, cout_q;
  logic             accept, last;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Result is shifted in from the MSB end, so after WIDTH slices bit k holds
  // the slice output produced for operand bit k.
  always_comb begin
    res_next            = res_q >> 1;
    res_next[WIDTH-1]   = alu_s;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        op_q    <= op;
        // Preloading the carry register with cin0 makes k=0 look like any other slice.
        carry_q <= cin0;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        carry_q <= alu_cout;
        res_q   <= res_next;
        if (last) begin
          cout_q <= alu_cout;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign ready   = (state != RUN);
  assign done    = (state == DONE);
  assign alu_a   = (state == RUN) && a_sh[0];
  assign alu_b   = (state == RUN) && b_sh[0];
  assign alu_cin = (state == RUN) && carry_q;
  assign alu_op  = op_q;
  assign result  = res_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - directed self-checking bench for serial_alu_ctrl
module tb_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [1:0] op = '0;
  logic       cin0 = 1'b0;
  logic       ready, alu_a, alu_b, alu_cin, alu_s, alu_cout, cout, done;
  logic [1:0] alu_op;
  logic [7:0] result;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [1:0] op1 = '0;
  logic       cin01 = 1'b0;
  logic       ready1, alu_a1, alu_b1, alu_cin1, alu_s1, alu_cout1, cout1, done1;
  logic [1:0] alu_op1;
  logic [0:0] result1;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op), .cin0(cin0),
    .ready(ready), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout), .result(result), .cout(cout), .done(done)
  );

  serial_alu_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .op(op1), .cin0(cin01),
    .ready(ready1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_cin(alu_cin1), .alu_op(alu_op1),
    .alu_s(alu_s1), .alu_cout(alu_cout1), .result(result1), .cout(cout1), .done(done1)
  );

  // Slice model: 11 full adder, 00 AND, 01 OR, 10 XOR; only the adder carries.
  function automatic logic [1:0] slice(input logic [1:0] o, input logic x, input logic y, input logic c);
    case (o)
      2'b11:   slice = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
      2'b00:   slice = {1'b0, x & y};
      2'b01:   slice = {1'b0, x | y};
      default: slice = {1'b0, x ^ y};
    endcase
  endfunction

  always_comb {alu_cout, alu_s} = slice(alu_op, alu_a, alu_b, alu_cin);
  always_comb {alu_cout1, alu_s1} = slice(alu_op1, alu_a1, alu_b1, alu_cin1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 30) begin
      step();
      cnt++;
    end
  endtask

  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop, input logic vc);
    a = va; b = vb; op = vop; cin0 = vc; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_alu", {alu_a, alu_b, alu_cin, alu_op}, 0);
    chk("rst_ready_w1", ready1, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 0x05 + 0x03
    launch(8'h05, 8'h03, 2'b11, 1'b0);
    chk("add1_busy", ready, 0);
    wait_done(n);
    chk("add1_latency", n, 8);
    chk("add1_result", result, 8'h08);
    chk("add1_cout", cout, 0);
    chk("add1_ready", ready, 1);
    step();
    chk("add1_done_pulse", done, 0);

    // 0xFF + 0x01: carry ripples through every slice
    launch(8'hFF, 8'h01, 2'b11, 1'b0);
    chk("add2_k0_cin", alu_cin, 0);
    chk("add2_k0_ab", {alu_a, alu_b}, 2'b11);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("add2_k%0d_cin", k), alu_cin, 1);
    end
    wait_done(n);
    chk("add2_latency", n, 1);
    chk("add2_result", result, 8'h00);
    chk("add2_cout", cout, 1);
    step();

    // AND with start and operand change mid-run
    launch(8'hF0, 8'h3C, 2'b00, 1'b0);
    step();
    step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    chk("and_busy", ready, 0);
    wait_done(n);
    chk("and_latency", n, 5);
    chk("and_result", result, 8'h30);
    chk("and_cout", cout, 0);
    chk("and_op_hold", alu_op, 2'b00);
    step();
    chk("idle_op_hold", alu_op, 2'b00);
    chk("idle_alu_zero", {alu_a, alu_b, alu_cin}, 0);

    // Reset at k=3
    launch(8'h05, 8'h03, 2'b11, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end
    chk("abort_idle", ready, 1);
    launch(8'h05, 8'h03, 2'b11, 1'b0);
    wait_done(n);
    chk("fresh_latency", n, 8);
    chk("fresh_result", result, 8'h08);
    step();

    // Back-to-back with start held high
    a = 8'h05; b = 8'h03; op = 2'b11; cin0 = 1'b0; start = 1'b1;
    step();
    wait_done(n);
    chk("b2b1_latency", n, 8);
    chk("b2b1_result", result, 8'h08);
    a = 8'h10; b = 8'h20;
    step();
    chk("b2b_no_idle", ready, 0);
    chk("b2b_done_low", done, 0);
    wait_done(n);
    chk("b2b2_period", n + 1, 9);
    chk("b2b2_result", result, 8'h30);
    start = 1'b0;
    step();
    chk("b2b_end_idle", ready, 1);
    chk("b2b_end_done", done, 0);

    // WIDTH=1: 1 + 1 + 1
    a1 = 1'b1; b1 = 1'b1; op1 = 2'b11; cin01 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("w1_busy", ready1, 0);
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("w1_latency", n, 1);
    chk("w1_result", result1, 1);
    chk("w1_cout", cout1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
